// File: rtl/cryptoveril_pkg.sv
// cryptoveril_pkg: shared limits and width-generic rotate/round-key helpers for the cipher pipeline
package cryptoveril_pkg;
  localparam int MAX_ROUNDS = 16;
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;
  function automatic word_t wmask(int w);
    return w >= MAX_W ? '1 : (word_t'(1) << w) - word_t'(1);
  endfunction
  function automatic word_t rotl(word_t x, int sh, int w);
    word_t m;
    word_t v;
    m = wmask(w);
    v = x & m;
    return ((v << sh) | (v >> (w - sh))) & m;
  endfunction
  function automatic word_t rotr(word_t x, int sh, int w);
    word_t m;
    word_t v;
    m = wmask(w);
    v = x & m;
    return ((v >> sh) | (v << (w - sh))) & m;
  endfunction
  function automatic word_t round_key(word_t key, int i, int w);
    return (key + word_t'(i)) & wmask(w);
  endfunction
  // w is a power of two, so masking the round key equals (key + i) mod w
  function automatic int round_shift(word_t key, int i, int w);
    return int'(round_key(key, i, w) & word_t'(w - 1));
  endfunction
endpackage

// File: rtl/cryptoveril_if.sv
// cryptoveril_if: key-load, input and output handshakes; in_dec exists only with CRYPTOVERIL_DEC_EN
interface cryptoveril_if #(
  parameter int DATA_W = 16,
  parameter int KEY_W = 5
);
  logic [KEY_W-1:0] key_in;
  logic key_ld;
  logic key_ready;
  logic [DATA_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
`ifdef CRYPTOVERIL_DEC_EN
  logic in_dec;
`endif
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (
    output key_in, key_ld, in_data, in_valid, out_ready,
`ifdef CRYPTOVERIL_DEC_EN
    output in_dec,
`endif
    input key_ready, in_ready, out_data, out_valid
  );
  modport slave (
    input key_in, key_ld, in_data, in_valid, out_ready,
`ifdef CRYPTOVERIL_DEC_EN
    input in_dec,
`endif
    output key_ready, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/cryptoveril_round.sv
// cryptoveril_round: one registered cipher round carrying data, key, valid (and dec with CRYPTOVERIL_DEC_EN)
module cryptoveril_round
  import cryptoveril_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KEY_W = 5,
  parameter int ROUNDS = 3,
  parameter int IDX = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic v_in,
  input  logic [DATA_W-1:0] x_in,
  input  logic [KEY_W-1:0] k_in,
`ifdef CRYPTOVERIL_DEC_EN
  input  logic d_in,
  output logic d,
`endif
  output logic v,
  output logic [DATA_W-1:0] x,
  output logic [KEY_W-1:0] k
);
  localparam int INV = ROUNDS - 1 - IDX;
  word_t kw;
  logic [DATA_W-1:0] x_enc;
  logic [DATA_W-1:0] x_nxt;
  assign kw = word_t'(k_in);
  assign x_enc = DATA_W'(rotl(word_t'(x_in) ^ round_key(kw, IDX, DATA_W),
                              round_shift(kw, IDX, DATA_W), DATA_W));
`ifdef CRYPTOVERIL_DEC_EN
  logic [DATA_W-1:0] x_dec;
  // decrypt walks the rounds backwards: this stage undoes round ROUNDS-1-IDX
  assign x_dec = DATA_W'(rotr(word_t'(x_in), round_shift(kw, INV, DATA_W), DATA_W)
                         ^ round_key(kw, INV, DATA_W));
  assign x_nxt = d_in ? x_dec : x_enc;
  always_ff @(posedge clk)
    if (rst) d <= 1'b0;
    else if (en) d <= d_in;
`else
  assign x_nxt = x_enc;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      x <= '0;
      k <= '0;
    end else if (en) begin
      v <= v_in;
      x <= x_nxt;
      k <= k_in;
    end
  end
endmodule

// File: rtl/cryptoveril_pipe.sv
// cryptoveril_pipe: ROUNDS-deep keyed cipher pipeline with full back-pressure and gated key load
// Optional decrypt path enabled by defining CRYPTOVERIL_DEC_EN.
module cryptoveril_pipe
  import cryptoveril_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KEY_W = 5,
  parameter int ROUNDS = 3
) (
  input logic clk,
  input logic rst,
  cryptoveril_if.slave bus
);
  logic adv;
  logic key_ok;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] key_cur;
  logic [ROUNDS-1:0] v_src;
  logic [ROUNDS-1:0] v_s;
  logic [DATA_W-1:0] x_src [ROUNDS];
  logic [DATA_W-1:0] x_s [ROUNDS];
  logic [KEY_W-1:0] k_src [ROUNDS];
  logic [KEY_W-1:0] k_s [ROUNDS];
`ifdef CRYPTOVERIL_DEC_EN
  logic d_src [ROUNDS];
  logic d_s [ROUNDS];
`endif
  assign adv = !v_s[ROUNDS-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.key_ready = ~|v_s;
  assign bus.out_valid = v_s[ROUNDS-1];
  assign bus.out_data = x_s[ROUNDS-1];
  assign key_ok = bus.key_ld && bus.key_ready;
  // a word accepted alongside a key load must see the new key
  assign key_cur = key_ok ? bus.key_in : key_reg;
  always_ff @(posedge clk)
    if (rst) key_reg <= '0;
    else if (key_ok) key_reg <= bus.key_in;
  for (genvar g = 0; g < ROUNDS; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign v_src[g] = bus.in_valid;
      assign x_src[g] = bus.in_data;
      assign k_src[g] = key_cur;
`ifdef CRYPTOVERIL_DEC_EN
      assign d_src[g] = bus.in_dec;
`endif
    end else begin : g_link
      assign v_src[g] = v_s[g-1];
      assign x_src[g] = x_s[g-1];
      assign k_src[g] = k_s[g-1];
`ifdef CRYPTOVERIL_DEC_EN
      assign d_src[g] = d_s[g-1];
`endif
    end
    cryptoveril_round #(
      .DATA_W(DATA_W),
      .KEY_W(KEY_W),
      .ROUNDS(ROUNDS),
      .IDX(g)
    ) u_round (
      .clk(clk),
      .rst(rst),
      .en(adv),
      .v_in(v_src[g]),
      .x_in(x_src[g]),
      .k_in(k_src[g]),
`ifdef CRYPTOVERIL_DEC_EN
      .d_in(d_src[g]),
      .d(d_s[g]),
`endif
      .v(v_s[g]),
      .x(x_s[g]),
      .k(k_s[g])
    );
  end
endmodule
